// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the aes_engine command sequencer.
// Byte index 0 always refers to the most significant byte of a 128-bit block.
package aes_seq_pkg;

  localparam int NBYTES = 16;
  localparam int BLK_W  = NBYTES * 8;
  localparam int IDX_W  = $clog2(NBYTES);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_KEY  = 2'b01;
  localparam logic [1:0] CMD_DATA = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    DATA,
    RECV,
    RESP
  } state_t;

  // Translate a send/receive order index into its packed byte position.
  function automatic logic [IDX_W-1:0] byte_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(NBYTES - 1) - idx;
  endfunction

endpackage

// File: rtl/aes_byte_collector.sv
// Capture register for the result block: engine bytes are written MSB first by
// index, and the whole block can be cleared synchronously.
module aes_byte_collector
  import aes_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       din,
  output logic [BLK_W-1:0] data
);

  logic [NBYTES-1:0][7:0] cap_q;

  // NOTE: the capture block is cleared by reset on purpose, because rsp_data is
  // architecturally visible and must read zero before the first response.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cap_q <= '0;
    end else if (we) begin
      cap_q[byte_pos(idx)] <= din;
    end
  end

  assign data = cap_q;

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Serialises 128-bit key/plaintext requests onto the byte-wide aes_engine port
// and gathers the 16 result bytes into one response, tracking key residency.
module aes_cmd_sequencer
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_key_load,
  input  logic [BLK_W-1:0] req_key,
  input  logic [BLK_W-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BLK_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             key_loaded,
  output logic [1:0]       eng_cmd,
  output logic [7:0]       eng_din,
  input  logic             eng_ready,
  input  logic             eng_ok,
  input  logic [7:0]       eng_dout
);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             timer;
  logic [NBYTES-1:0][7:0] key_q;
  logic [NBYTES-1:0][7:0] data_q;

  logic       last_idx;
  logic       timeout_hit;
  logic       cap_clr;
  logic       cap_we;
  logic [7:0] sel_byte;

  assign last_idx    = (idx == IDX_W'(NBYTES - 1));
  assign timeout_hit = (state == RECV) && !eng_ok && (timer == 8'(TIMEOUT - 1));
  assign cap_we      = (state == RECV) && eng_ok;
  assign cap_clr     = ((state == IDLE) && req_valid) || timeout_hit;

  // 16:1 byte mux feeding the engine while a block is being streamed out.
  assign sel_byte = (state == KEY) ? key_q[byte_pos(idx)] : data_q[byte_pos(idx)];

  // NOTE: every output gets a default before the case so no state can leave a
  // path unassigned and infer a latch.
  always_comb begin
    eng_cmd = CMD_NOP;
    eng_din = '0;
    case (state)
      KEY: begin
        eng_cmd = CMD_KEY;
        eng_din = sel_byte;
      end
      DATA: begin
        eng_cmd = CMD_DATA;
        eng_din = sel_byte;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every branch sees the
  // pre-edge values of state, idx and timer regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      key_q      <= '0;
      data_q     <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            key_q     <= req_key;
            data_q    <= req_data;
            idx       <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b0;
            if (req_key_load) begin
              key_loaded <= 1'b0;
              state      <= KEY;
            end else if (key_loaded) begin
              state <= DATA;
            end else begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        KEY: begin
          if (eng_ready) begin
            if (last_idx) begin
              key_loaded <= 1'b1;
              idx        <= '0;
              state      <= DATA;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DATA: begin
          if (eng_ready) begin
            if (last_idx) begin
              idx   <= '0;
              timer <= '0;
              state <= RECV;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RECV: begin
          if (eng_ok) begin
            timer <= '0;
            if (last_idx) begin
              idx       <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (timeout_hit) begin
            // Engine went silent mid-result; its internal state is unknown.
            timer      <= '0;
            idx        <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            key_loaded <= 1'b0;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  aes_byte_collector u_collector (
    .clk  (clk),
    .rst  (rst),
    .clr  (cap_clr),
    .we   (cap_we),
    .idx  (idx),
    .din  (eng_dout),
    .data (rsp_data)
  );

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Self-checking bench: behavioural aes_engine stand-in with random ready duty,
// a transaction-level reference model compared every cycle, and directed tests.
module tb_aes_cmd_sequencer;

  localparam int TIMEOUT = 255;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_key_load = 1'b0;
  logic [127:0] req_key = '0;
  logic [127:0] req_data = '0;
  logic         rsp_ready = 1'b0;
  logic         eng_ready = 1'b0;
  logic         eng_ok = 1'b0;
  logic [7:0]   eng_dout = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         key_loaded;
  logic [1:0]   eng_cmd;
  logic [7:0]   eng_din;

  always #5 clk = ~clk;

  aes_cmd_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key_load (req_key_load),
    .req_key      (req_key),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .key_loaded   (key_loaded),
    .eng_cmd      (eng_cmd),
    .eng_din      (eng_din),
    .eng_ready    (eng_ready),
    .eng_ok       (eng_ok),
    .eng_dout     (eng_dout)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine stand-in: the real FIPS-197 vector, otherwise a cheap keyed mix.
  function automatic logic [127:0] engine_result(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural aes_engine ----------------
  logic [127:0] e_key = '0, e_pt = '0, e_res = '0;
  int  e_dcnt = 0, e_lat = 0, e_out = 0;
  bit  e_emit = 0;
  int  stall_after = 16;
  bit  stray_ok = 0;
  int  ready_pct = 70;
  int  e_kbytes = 0, e_dbytes = 0, cmd_cycles = 0;
  int  ok5_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      eng_ok = 1'b0;
      if (rst) begin
        eng_ready = 1'b0;
        e_dcnt = 0;
        e_emit = 0;
      end else begin
        eng_ready = ($urandom_range(99) < ready_pct);
        if (eng_cmd != 2'b00) cmd_cycles++;
        if (eng_cmd == 2'b01 && eng_ready) begin
          e_key = {e_key[119:0], eng_din};
          e_kbytes++;
        end else if (eng_cmd == 2'b10 && eng_ready) begin
          e_pt = {e_pt[119:0], eng_din};
          e_dbytes++;
          e_dcnt++;
          if (e_dcnt == 16) begin
            e_dcnt = 0;
            e_res  = engine_result(e_key, e_pt);
            e_lat  = $urandom_range(4);
            e_out  = 0;
            e_emit = 1;
          end
        end else if (e_emit) begin
          if (e_lat > 0) e_lat--;
          else if (e_out >= stall_after) e_emit = 0;
          else if ($urandom_range(2) != 0) begin
            eng_ok   = 1'b1;
            eng_dout = 8'(e_res >> (8 * (15 - e_out)));
            e_out++;
            if (e_out == 5) ok5_cyc = cyc + 1;
            if (e_out == 16) e_emit = 0;
          end
        end else if (stray_ok) begin
          eng_ok   = 1'b1;
          eng_dout = 8'hEE;
          stray_ok = 0;
        end
      end
    end
  end

  // ---------------- reference model (transaction counters) ----------------
  int  m_pk = 0, m_pd = 0, m_got = 0, m_idle = 0;
  bit  m_recv = 0, m_resp = 0, m_err = 0, m_keyok = 0;
  logic [127:0] m_key = '0, m_pt = '0, m_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pk <= 0; m_pd <= 0; m_got <= 0; m_idle <= 0;
      m_recv <= 0; m_resp <= 0; m_err <= 0; m_keyok <= 0; m_data <= '0;
    end else if (m_pk > 0) begin
      if (eng_ready) begin
        m_pk <= m_pk - 1;
        if (m_pk == 1) m_keyok <= 1;
      end
    end else if (m_pd > 0) begin
      if (eng_ready) begin
        m_pd <= m_pd - 1;
        if (m_pd == 1) begin m_recv <= 1; m_got <= 0; m_idle <= 0; end
      end
    end else if (m_recv) begin
      if (eng_ok) begin
        m_data <= m_data | (128'(eng_dout) << (8 * (15 - m_got)));
        m_got  <= m_got + 1;
        m_idle <= 0;
        if (m_got == 15) begin m_recv <= 0; m_resp <= 1; end
      end else begin
        m_idle <= m_idle + 1;
        if (m_idle == TIMEOUT - 1) begin
          m_recv <= 0; m_resp <= 1; m_err <= 1; m_data <= '0; m_keyok <= 0;
        end
      end
    end else if (m_resp) begin
      if (rsp_ready) m_resp <= 0;
    end else if (req_valid) begin
      m_key <= req_key; m_pt <= req_data; m_data <= '0; m_err <= 0;
      if (req_key_load) begin m_keyok <= 0; m_pk <= 16; m_pd <= 16; end
      else if (m_keyok) m_pd <= 16;
      else begin m_resp <= 1; m_err <= 1; end
    end
  end

  bit mon_en = 0;

  initial begin
    logic [1:0] exp_cmd;
    logic [7:0] exp_din;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_cmd = (m_pk > 0) ? 2'b01 : (m_pd > 0) ? 2'b10 : 2'b00;
        exp_din = (m_pk > 0) ? 8'(m_key >> (8 * (m_pk - 1))) :
                  (m_pd > 0) ? 8'(m_pt >> (8 * (m_pd - 1))) : 8'h00;
        check("mdl_req_ready", req_ready, (m_pk == 0 && m_pd == 0 && !m_recv && !m_resp));
        check("mdl_rsp_valid", rsp_valid, m_resp);
        check("mdl_rsp_err", rsp_err, m_err);
        check("mdl_rsp_data", rsp_data, m_data);
        check("mdl_key_loaded", key_loaded, m_keyok);
        check("mdl_eng_cmd", eng_cmd, exp_cmd);
        check("mdl_eng_din", eng_din, exp_din);
      end
    end
  end

  // ---------------- directed / random stimulus ----------------
  bit sb_valid = 0;
  logic [127:0] sb_key = '0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [127:0] k, input logic [127:0] p, input bit kl);
    int n = 0;
    while (!req_ready && n < 3000) begin tick(); n++; end
    check("wait_req_ready", req_ready, 1'b1);
    req_key = k; req_data = p; req_key_load = kl; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 3000) begin tick(); n++; end
    check({tag, "_wait_rsp_valid"}, rsp_valid, 1'b1);
  endtask

  task automatic finish_rsp(input string tag, input logic [127:0] exp_d, input bit exp_e, input int hold);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_req_ready"}, req_ready, 1'b0);
      check({tag, "_hold_data"}, rsp_data, exp_d);
      tick();
    end
    check({tag, "_rsp_data"}, rsp_data, exp_d);
    check({tag, "_rsp_err"}, rsp_err, exp_e);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic run_req(input string tag, input logic [127:0] k, input logic [127:0] p,
                         input bit kl, input int hold, output logic [127:0] got);
    logic [127:0] exp_d;
    bit exp_e;
    if (kl) begin sb_key = k; sb_valid = 1; end
    exp_e = !sb_valid;
    exp_d = exp_e ? '0 : engine_result(sb_key, p);
    issue(k, p, kl);
    wait_rsp(tag);
    got = rsp_data;
    finish_rsp(tag, exp_d, exp_e, hold);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_valid = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required less", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0] got, k, p;
    int base_k, base_d, base_c, n;

    tick();
    mon_en = 1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 128'h0);
    check("rst_key_loaded", key_loaded, 1'b0);
    check("rst_eng_cmd", eng_cmd, 2'b00);
    tick();
    rst = 1'b0;
    tick();

    // 1: key load plus FIPS-197 plaintext
    base_k = e_kbytes; base_d = e_dbytes;
    run_req("t1", FIPS_KEY, FIPS_PT, 1'b1, 0, got);
    check("t1_ct_literal", got, FIPS_CT);
    check("t1_key_bytes", e_kbytes - base_k, 16);
    check("t1_data_bytes", e_dbytes - base_d, 16);
    check("t1_engine_key", e_key, FIPS_KEY);
    check("t1_engine_pt", e_pt, FIPS_PT);
    check("t1_key_loaded", key_loaded, 1'b1);

    // 2: resident key reused
    base_k = e_kbytes;
    run_req("t2", 128'h0, FIPS_PT, 1'b0, 1, got);
    check("t2_ct_literal", got, FIPS_CT);
    check("t2_no_key_bytes", e_kbytes - base_k, 0);
    check("t2_key_loaded", key_loaded, 1'b1);

    // 6: held response, then a stray eng_ok in IDLE
    p = {$urandom, $urandom, $urandom, $urandom};
    run_req("t6", 128'h0, p, 1'b0, 20, got);
    stray_ok = 1;
    repeat (3) tick();
    check("t6_stray_no_capture", rsp_data, engine_result(FIPS_KEY, p));
    check("t6_stray_req_ready", req_ready, 1'b1);

    // 4: engine stalls after 5 result bytes
    stall_after = 5;
    issue(128'h0, FIPS_PT, 1'b0);
    wait_rsp("t4");
    check("t4_timeout_cycles", cyc - ok5_cyc, TIMEOUT);
    check("t4_key_loaded", key_loaded, 1'b0);
    finish_rsp("t4", 128'h0, 1'b1, 2);
    sb_valid = 0;
    stall_after = 16;

    // 3: no key straight after reset
    pulse_reset();
    base_c = cmd_cycles;
    run_req("t3", 128'h0, FIPS_PT, 1'b0, 0, got);
    check("t3_data_zero", got, 128'h0);
    check("t3_no_engine_traffic", cmd_cycles - base_c, 0);

    // 5: reset after 7 key bytes
    base_k = e_kbytes;
    issue(FIPS_KEY, FIPS_PT, 1'b1);
    n = 0;
    while (e_kbytes - base_k < 7 && n < 500) begin tick(); n++; end
    check("t5_seven_key_bytes", e_kbytes - base_k, 7);
    pulse_reset();
    check("t5_req_ready", req_ready, 1'b1);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_rsp_err", rsp_err, 1'b0);
    check("t5_rsp_data", rsp_data, 128'h0);
    check("t5_key_loaded", key_loaded, 1'b0);
    check("t5_eng_cmd", eng_cmd, 2'b00);
    check("t5_eng_din", eng_din, 8'h00);
    run_req("t5b", 128'h0, FIPS_PT, 1'b0, 0, got);

    // Randomised traffic with varying engine duty cycle
    for (int i = 0; i < 25; i++) begin
      ready_pct = $urandom_range(100, 30);
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_req("rnd", k, p, ($urandom_range(2) == 0), $urandom_range(3), got);
    end
    ready_pct = 70;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
